return_address_stack: RTL and testbench

- Return-address predictor between fetch and the branch unit.
- Fetch pushes the return address on a predicted call and pops on a predicted return. The top entry gives the predicted target of the next return.
- The branch unit's resolved results (br_results, branch_flush) keep a committed copy of the stack pointer, which repairs the speculative pointer after a mispredict flush.

---
 rtl/return_address_stack_pkg.sv | 25 ++
 rtl/return_address_stack_if.sv | 25 ++
 rtl/return_address_stack_ptr_tracker.sv | 59 +++++
 rtl/return_address_stack.sv | 75 +++++++
 tb/tb_return_address_stack.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/return_address_stack_pkg.sv
// Shared types for the return-address predictor: stack op encoding, resolved-branch record, default depth.
// Pure declarations; no timing or flow-control behaviour of its own.
package return_address_stack_pkg;

    localparam int RAS_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        RAS_NONE     = 2'b00,
        RAS_POP      = 2'b01,
        RAS_PUSH     = 2'b10,
        RAS_PUSH_POP = 2'b11
    } ras_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        is_call;
        logic        is_return;
    } branch_results_t;

    function automatic ras_op_t to_ras_op(input logic push, input logic pop);
        return ras_op_t'({push, pop});
    endfunction

endpackage

// File: rtl/return_address_stack_if.sv
// Fetch/branch-unit signal bundle for the return-address stack.
// Master drives requests and resolved branches; slave (the stack) returns the predicted target.
interface return_address_stack_if;
    import return_address_stack_pkg::*;

    logic            fetch_push;
    logic [31:0]     fetch_push_addr;
    logic            fetch_pop;
    logic [31:0]     ras_top_addr;
    logic            ras_top_valid;
    branch_results_t br_results;
    logic            branch_flush;
    logic            gc_flush;

    modport master (
        output fetch_push, fetch_push_addr, fetch_pop, br_results, branch_flush, gc_flush,
        input  ras_top_addr, ras_top_valid
    );

    modport slave (
        input  fetch_push, fetch_push_addr, fetch_pop, br_results, branch_flush, gc_flush,
        output ras_top_addr, ras_top_valid
    );

endinterface

// File: rtl/return_address_stack_ptr_tracker.sv
// Stack pointer + saturating occupancy count driven by a ras_op_t, with an override load.
// One-cycle update; upd_* outputs expose the post-op value before any load; never stalls.
module ras_ptr_tracker
    import return_address_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  ras_op_t          op_i,
    input  logic             load_i,
    input  logic [PTR_W-1:0] load_ptr_i,
    input  logic [PTR_W:0]   load_count_i,
    output logic [PTR_W-1:0] ptr_o,
    output logic [PTR_W:0]   count_o,
    output logic [PTR_W-1:0] upd_ptr_o,
    output logic [PTR_W:0]   upd_count_o
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        upd_ptr_o   = ptr_q;
        upd_count_o = count_q;
        case (op_i)
            RAS_PUSH: begin
                upd_ptr_o   = ptr_q + PTR_W'(1);
                upd_count_o = (count_q == FULL) ? FULL : count_q + (PTR_W+1)'(1);
            end
            RAS_POP: begin
                // Pointer moves even when empty so it stays in step with the other tracker.
                upd_ptr_o   = ptr_q - PTR_W'(1);
                upd_count_o = (count_q == '0) ? '0 : count_q - (PTR_W+1)'(1);
            end
            default: ;
        endcase
    end

    assign ptr_d   = load_i ? load_ptr_i   : upd_ptr_o;
    assign count_d = load_i ? load_count_i : upd_count_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign ptr_o   = ptr_q;
    assign count_o = count_q;

endmodule

// File: rtl/return_address_stack.sv
// Return-address predictor: speculative stack from fetch, committed pointer from the branch unit for flush repair.
// Top-of-stack read is combinational (zero latency, no same-cycle bypass); accepts every request, no backpressure.
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    return_address_stack_if.slave   ras
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0] stack_q [DEPTH];

    logic             flush;
    ras_op_t          spec_op, commit_op;
    logic [PTR_W-1:0] spec_ptr, spec_upd_ptr, commit_ptr, commit_upd_ptr;
    logic [PTR_W:0]   spec_count, spec_upd_count, commit_count, commit_upd_count;
    logic             spec_we, repair_we;
    logic [31:0]      repair_dat;

    assign flush = (ras.branch_flush & ras.br_results.valid) | ras.gc_flush;

    assign spec_op   = flush ? RAS_NONE : to_ras_op(ras.fetch_push, ras.fetch_pop);
    assign commit_op = ras.br_results.valid
                     ? to_ras_op(ras.br_results.is_call, ras.br_results.is_return)
                     : RAS_NONE;

    ras_ptr_tracker #(.DEPTH(DEPTH)) spec_trk (
        .clk_i        (clk),
        .rst_i        (rst),
        .op_i         (spec_op),
        .load_i       (flush),
        .load_ptr_i   (commit_upd_ptr),
        .load_count_i (commit_upd_count),
        .ptr_o        (spec_ptr),
        .count_o      (spec_count),
        .upd_ptr_o    (spec_upd_ptr),
        .upd_count_o  (spec_upd_count)
    );

    ras_ptr_tracker #(.DEPTH(DEPTH)) commit_trk (
        .clk_i        (clk),
        .rst_i        (rst),
        .op_i         (commit_op),
        .load_i       (1'b0),
        .load_ptr_i   ('0),
        .load_count_i ('0),
        .ptr_o        (commit_ptr),
        .count_o      (commit_count),
        .upd_ptr_o    (commit_upd_ptr),
        .upd_count_o  (commit_upd_count)
    );

    // Push and push+pop both write at the post-op pointer, so the updated pointer is the write index.
    assign spec_we    = ras.fetch_push & ~flush;
    assign repair_we  = ras.br_results.valid & ras.br_results.is_call;
    assign repair_dat = ras.br_results.pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (repair_we)
                stack_q[commit_upd_ptr] <= repair_dat;
            // Later assignment wins a same-index collision with the repair write.
            if (spec_we)
                stack_q[spec_upd_ptr] <= ras.fetch_push_addr;
        end
    end

    assign ras.ras_top_addr  = stack_q[spec_ptr];
    assign ras.ras_top_valid = (spec_count != '0);

endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack (DEPTH=8).
module tb_return_address_stack;
    import return_address_stack_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    return_address_stack_if ras_if ();

    return_address_stack #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .ras (ras_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_top(input string tag, input logic [31:0] exp_addr);
        chk({tag, "_valid"}, {31'd0, ras_if.ras_top_valid}, 32'd1);
        chk({tag, "_addr"}, ras_if.ras_top_addr, exp_addr);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {31'd0, ras_if.ras_top_valid}, 32'd0);
    endtask

    task automatic clr();
        ras_if.fetch_push      = 1'b0;
        ras_if.fetch_push_addr = 32'd0;
        ras_if.fetch_pop       = 1'b0;
        ras_if.br_results      = '0;
        ras_if.branch_flush    = 1'b0;
        ras_if.gc_flush        = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr();
        cyc();
        rst = 1'b1;
    endtask

    task automatic do_push(input logic [31:0] a);
        ras_if.fetch_push      = 1'b1;
        ras_if.fetch_push_addr = a;
        cyc();
        clr();
    endtask

    task automatic do_pop();
        ras_if.fetch_pop = 1'b1;
        cyc();
        clr();
    endtask

    task automatic set_br(input logic [31:0] pc, input logic call, input logic ret);
        ras_if.br_results = '{valid: 1'b1, pc: pc, is_call: call, is_return: ret};
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        clr();
        cyc();
        cyc();
        chk_empty("reset");
        rst = 1'b1;

        // Basic push/pop
        do_push(32'h100);
        do_push(32'h200);
        do_push(32'h300);
        chk_top("push3", 32'h300);
        do_pop();
        chk_top("pop1", 32'h200);
        do_pop();
        chk_top("pop2", 32'h100);
        do_pop();
        chk_empty("pop3");
        do_pop();
        chk_empty("pop_empty");

        // Overflow: 9 pushes into 8 entries
        do_reset();
        for (int i = 0; i < 9; i++) do_push(32'h1000 + 32'(4 * i));
        chk_top("wrap_top", 32'h1020);
        for (int k = 1; k <= 7; k++) begin
            do_pop();
            chk_top($sformatf("wrap_pop%0d", k), 32'h1020 - 32'(4 * k));
        end
        do_pop();
        chk_empty("wrap_pop8");
        do_pop();
        chk_empty("wrap_pop9");

        // Same-cycle push and pop replaces the top
        do_reset();
        do_push(32'h40);
        do_push(32'h80);
        ras_if.fetch_push      = 1'b1;
        ras_if.fetch_push_addr = 32'hA0;
        ras_if.fetch_pop       = 1'b1;
        cyc();
        clr();
        chk_top("pushpop", 32'hA0);
        do_pop();
        chk_top("pushpop_below", 32'h40);
        do_pop();
        chk_empty("pushpop_cnt2");

        // Commit call, younger speculative pushes, mispredict flush
        do_reset();
        do_push(32'h2004);
        set_br(32'h2000, 1'b1, 1'b0);
        cyc();
        clr();
        do_push(32'h500);
        do_push(32'h600);
        chk_top("spec_before_flush", 32'h600);
        set_br(32'h0, 1'b0, 1'b0);
        ras_if.branch_flush = 1'b1;
        cyc();
        clr();
        chk_top("flush_top", 32'h2004);
        do_pop();
        chk_empty("flush_cnt1");

        // branch_flush without br_results.valid is not a flush
        do_reset();
        do_push(32'h77);
        ras_if.branch_flush = 1'b1;
        cyc();
        clr();
        chk_top("flush_unqualified", 32'h77);

        // Commit return with flush: commit count 2 -> 1, fetch push dropped
        do_reset();
        set_br(32'h3000, 1'b1, 1'b0);
        cyc();
        set_br(32'h3100, 1'b1, 1'b0);
        cyc();
        clr();
        chk_empty("commit_only_spec");
        set_br(32'h0, 1'b0, 1'b1);
        ras_if.branch_flush    = 1'b1;
        ras_if.fetch_push      = 1'b1;
        ras_if.fetch_push_addr = 32'hDEAD0000;
        cyc();
        clr();
        chk_top("ret_flush_top", 32'h3004);
        do_pop();
        chk_empty("ret_flush_cnt1");

        // Same-index spec and repair write in a non-flush cycle: spec wins
        do_reset();
        set_br(32'h9000, 1'b1, 1'b0);
        ras_if.fetch_push      = 1'b1;
        ras_if.fetch_push_addr = 32'h8000;
        cyc();
        clr();
        chk_top("wr_conflict", 32'h8000);

        // Mid-operation reset clears both sides
        do_reset();
        set_br(32'h10, 1'b1, 1'b0);
        cyc();
        clr();
        do_push(32'h100);
        do_push(32'h200);
        rst                    = 1'b0;
        ras_if.fetch_push      = 1'b1;
        ras_if.fetch_push_addr = 32'h300;
        ras_if.gc_flush        = 1'b1;
        cyc();
        clr();
        rst = 1'b1;
        chk_empty("mid_reset");
        do_push(32'h55);
        chk_top("post_reset_push", 32'h55);
        ras_if.gc_flush = 1'b1;
        cyc();
        clr();
        chk_empty("gc_flush_commit0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
